// File: rtl/arbiter_pkg.sv
// Shared helpers for the round-robin arbiter family: modulo increment and
// the effective-weight rule (a zero weight still grants one beat).
package arbiter_pkg;

  function automatic int inc_mod(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  function automatic int w_eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating first-one finder: first asserted req at or above start, wrapping
// modulo NumReq. Works for any NumReq, not only powers of two.
module rr_priority_select #(
  parameter int NumReq = 5,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   start,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx,
  output logic              valid
);

  always_comb begin
    int c;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    // Scan from the far end so the nearest hit to start is written last.
    for (int k = NumReq - 1; k >= 0; k--) begin
      c = int'(start) + k;
      if (c >= NumReq) c = c - NumReq;
      if (req[c]) begin
        valid = 1'b1;
        idx   = IdxW'(c);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: the granted requester keeps the bus for up
// to its weight in acknowledged beats, then priority rotates past it.
module weighted_rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NumReq      = 5,
  parameter int WeightWidth = 4,
  parameter int IdxW        = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*WeightWidth-1:0] weight_i,
  input  logic                          ack_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [IdxW-1:0]               gnt_idx_o,
  output logic                          gnt_valid_o
);

  logic                   lock_q, lock_next;
  logic [IdxW-1:0]        owner_q, owner_next;
  logic [WeightWidth-1:0] credit_q, credit_next;
  logic [IdxW-1:0]        ptr_q, ptr_next;

  logic                   continuing;
  logic [IdxW-1:0]        start;
  logic [NumReq-1:0]      sel_gnt;
  logic [IdxW-1:0]        sel_idx;
  logic                   sel_valid;
  logic [WeightWidth-1:0] w_sel;
  logic [WeightWidth-1:0] cur;

  // Starting the scan at the owner itself makes a continuing grant fall out
  // of the same finder; a dropped owner scans from its successor instead.
  always_comb begin
    continuing = lock_q && req_i[owner_q];
    if (!lock_q)        start = ptr_q;
    else if (continuing) start = owner_q;
    else                start = IdxW'(inc_mod(int'(owner_q), NumReq));
  end

  rr_priority_select #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_select (
    .req   (req_i),
    .start (start),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    w_sel = weight_i[int'(sel_idx)*WeightWidth +: WeightWidth];
    cur   = continuing ? credit_q : WeightWidth'(w_eff(int'(w_sel)));
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_q   <= 1'b0;
      owner_q  <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
    end else begin
      lock_q   <= lock_next;
      owner_q  <= owner_next;
      credit_q <= credit_next;
      ptr_q    <= ptr_next;
    end
  end

  always_comb begin
    lock_next   = lock_q;
    owner_next  = owner_q;
    credit_next = credit_q;
    ptr_next    = ptr_q;
    if (sel_valid) begin
      if (ack_i && cur == WeightWidth'(1)) begin
        lock_next = 1'b0;
        ptr_next  = IdxW'(inc_mod(int'(sel_idx), NumReq));
      end else begin
        // A stall keeps the credit; an accepted beat consumes one.
        lock_next   = 1'b1;
        owner_next  = sel_idx;
        credit_next = ack_i ? cur - 1'b1 : cur;
      end
    end else if (lock_q) begin
      lock_next = 1'b0;
      ptr_next  = IdxW'(inc_mod(int'(owner_q), NumReq));
    end
  end

  always_comb begin
    gnt_o       = sel_gnt;
    gnt_idx_o   = sel_idx;
    gnt_valid_o = sel_valid;
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed scenarios with literal grant
// sequences plus randomized traffic checked every cycle against a model.
module tb_weighted_rr_arbiter;

  localparam int N  = 5;
  localparam int WW = 4;
  localparam int IW = $clog2(N);

  logic            clk_i = 1'b0;
  logic            arst_ni = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic            ack = 1'b0;
  logic [N-1:0]    gnt_o;
  logic [IW-1:0]   gnt_idx_o;
  logic            gnt_valid_o;

  int errors = 0;
  int checks = 0;

  // Model state: whether a burst is held, by whom, beats left, next priority.
  int m_lock = 0, m_owner = 0, m_credit = 0, m_ptr = 0;

  weighted_rr_arbiter #(.NumReq(N), .WeightWidth(WW)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_i       (req),
    .weight_i    (weight),
    .ack_i       (ack),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wt(input int k);
    int w;
    w = int'(weight[k*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic void model_eval(input logic [N-1:0] r, output int idx,
                                     output int valid, output int cont);
    int s;
    idx = 0; valid = 0; cont = 0;
    if (m_lock != 0 && r[m_owner]) begin
      idx = m_owner; valid = 1; cont = 1;
      return;
    end
    s = (m_lock != 0) ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++) begin
      if (r[(s + k) % N]) begin
        idx = (s + k) % N; valid = 1;
        return;
      end
    end
  endfunction

  always @(posedge clk_i or negedge arst_ni) begin
    int idx, valid, cont, cur;
    if (!arst_ni) begin
      m_lock <= 0; m_owner <= 0; m_credit <= 0; m_ptr <= 0;
    end else begin
      model_eval(req, idx, valid, cont);
      if (valid != 0) begin
        cur = (cont != 0) ? m_credit : wt(idx);
        if (ack && cur == 1) begin
          m_lock <= 0; m_ptr <= (idx + 1) % N;
        end else begin
          m_lock <= 1; m_owner <= idx;
          m_credit <= ack ? cur - 1 : cur;
        end
      end else if (m_lock != 0) begin
        m_lock <= 0; m_ptr <= (m_owner + 1) % N;
      end
    end
  end

  always @(negedge clk_i) begin
    int idx, valid, cont;
    model_eval(req, idx, valid, cont);
    chk("gnt_valid", int'(gnt_valid_o), valid);
    chk("gnt_idx", int'(gnt_idx_o), idx);
    chk("gnt_onehot", int'(gnt_o), (valid != 0) ? (1 << idx) : 0);
  end

  task automatic step(input logic [N-1:0] r, input logic a, output int got);
    @(posedge clk_i); #1;
    req = r; ack = a;
    @(negedge clk_i); #1;
    got = int'(gnt_idx_o);
    $display("step req=%b ack=%0b gnt_idx=%0d valid=%0b", r, a, got, gnt_valid_o);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    arst_ni = 1'b0; req = '0; ack = 1'b0;
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
  endtask

  task automatic set_w(input int k, input int v);
    weight[k*WW +: WW] = WW'(v);
  endtask

  initial begin
    int got;
    int exp_fair[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    int exp_wgt[8]   = '{0, 0, 0, 2, 0, 0, 0, 2};
    int exp_wrap[6]  = '{0, 4, 0, 4, 0, 4};
    int exp_drop[7]  = '{3, 4, 3, 3, 3, 3, 4};

    #12;
    chk("reset_valid", int'(gnt_valid_o), 0);
    chk("reset_idx", int'(gnt_idx_o), 0);

    for (int k = 0; k < N; k++) set_w(k, 1);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(5'b11111, 1'b1, got);
      chk($sformatf("fair[%0d]", i), got, exp_fair[i]);
    end

    set_w(0, 3); set_w(2, 1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(5'b00101, 1'b1, got);
      chk($sformatf("weighted[%0d]", i), got, exp_wgt[i]);
    end

    set_w(1, 2);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(5'b00010, (i >= 4), got);
      chk($sformatf("stall[%0d]", i), got, 1);
    end

    set_w(3, 4); set_w(4, 1);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step((i == 1) ? 5'b10000 : 5'b11000, 1'b1, got);
      chk($sformatf("drop[%0d]", i), got, exp_drop[i]);
    end

    set_w(0, 1); set_w(4, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(5'b10001, 1'b1, got);
      chk($sformatf("wrap[%0d]", i), got, exp_wrap[i]);
    end

    set_w(1, 1); set_w(2, 5);
    do_reset();
    step(5'b00110, 1'b1, got);
    chk("rst_pre0", got, 1);
    step(5'b00110, 1'b1, got);
    chk("rst_pre1", got, 2);
    step(5'b00110, 1'b1, got);
    chk("rst_pre2", got, 2);
    #2 arst_ni = 1'b0;
    #1 chk("rst_same_cycle", int'(gnt_idx_o), 1);
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    #1 chk("rst_after_release", int'(gnt_idx_o), 1);
    step(5'b00110, 1'b1, got);
    chk("rst_post", got, 2);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #1;
      req = N'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) weight = (N*WW)'($urandom);
      arst_ni = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    @(negedge clk_i); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
Parametrised successor to the plain round-robin arbiter. Supports any requester count, not only powers of two, and gives each requester a programmable weight. A requester keeps the grant for up to weight accepted beats, then priority rotates to the next requester. A consumer acknowledge handshake makes the grant stable across back-pressure. The block sits in front of shared buses and memory ports, where burst fairness and grant stability matter.

Parameters:
NumReq, 5, number of requesters (>=2, any value)
WeightWidth, 4, bits per requester weight; max burst = 2**WeightWidth-1 beats
IdxW, (derived) $clog2(NumReq), width of grant index

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous active-low reset
req_i  in  NumReq  per-requester request, level
weight_i  in  NumReq*WeightWidth  packed weights; requester k at bits [k*WeightWidth +: WeightWidth]
ack_i  in  1  consumer accepts current granted beat
gnt_o  out  NumReq  one-hot grant (all-zero when idle)
gnt_idx_o  out  IdxW  index of granted requester (0 when idle)
gnt_valid_o  out  1  |gnt_o

Behaviour:
- Interface: one clock clk_i; reset arst_ni is asynchronous and active-low.
- State registers: lock_q, owner_q [IdxW], credit_q [WeightWidth], ptr_q [IdxW].
  - Reset values: all zero.
  - Outputs are combinational from state and req_i. No output register; zero-cycle grant latency.
- Effective weight: w_eff(k) = (weight_i[k]==0) ? 1 : weight_i[k]. The weight is sampled only when ownership starts.
- Grant select:
  - if lock_q && req_i[owner_q], grant owner_q (continuing grant);
  - otherwise grant the first asserted req_i found scanning upward from start, wrapping modulo NumReq (index NumReq-1 wraps to 0);
  - start = lock_q ? owner_q+1 (mod NumReq) : ptr_q;
  - no request: gnt_o=0, gnt_valid_o=0, gnt_idx_o=0.
- Beat credit: cur = continuing ? credit_q : w_eff(idx). Next state when gnt_valid_o:
  - ack_i=1, cur==1: lock_q<=0, ptr_q<=idx+1 (mod NumReq). Release; the next cycle arbitrates from the following requester.
  - ack_i=1, cur>1: lock_q<=1, owner_q<=idx, credit_q<=cur-1.
  - ack_i=0: lock_q<=1, owner_q<=idx, credit_q<=cur. The grant is frozen and no credit is consumed while stalled.
- Owner drops req_i while locked:
  - the lock is ignored in that same cycle and arbitration starts from owner_q+1;
  - if nothing else is requesting: lock_q<=0, ptr_q<=owner_q+1;
  - the remaining credit is discarded.
- A new request arriving while another requester is locked is never granted before the owner releases.
- Reset mid-burst: state clears asynchronously. gnt_o follows req_i with priority starting at index 0 in the same cycle.
- Fairness bound: an asserted requester waits at most sum over other requesters of (2**WeightWidth-1) acknowledged beats.

Decomposition:
- arbiter_pkg: a function for the modulo-NumReq increment, plus a w_eff helper. Shared with the existing round-robin arbiter bench.
- Sub-module rr_priority_select: combinational rotating first-one finder. Inputs: req vector and start index. Outputs: one-hot, index, valid. It must be correct for non-power-of-two NumReq and reusable by other arbiters.

Test Plan:
- Fairness, weights all 1, req_i=5'b11111, ack_i=1 for 10 cycles -> gnt_idx_o sequence 0,1,2,3,4,0,1,2,3,4.
- Weighted, weight0=3, weight2=1, req_i=5'b00101, ack_i=1 -> gnt_idx_o 0,0,0,2,0,0,0,2.
- Stall, weight1=2, req_i=5'b00010, ack_i low for 4 cycles then high -> gnt_idx_o=1 held for 4 stalled cycles plus 2 acked beats; lock_q clears after the second ack.
- Owner drop: weight3=4, req_i=5'b11000, drop req_i[3] after 1 ack -> in the same cycle gnt_idx_o=4; after requester 4's burst, requester 3 re-requests and gets a fresh 4-beat credit.
- Wrap and weight zero: weight4=0, req_i=5'b10001, ack_i=1 -> alternates 0,4,0,4 with one beat each; pointer wraps 4->0.
- Reset mid-burst: weight2=5, req_i=5'b00110, assert arst_ni low after 2 beats -> lock_q=0 immediately, gnt_idx_o=1 in the same cycle, requester 1 gets the full 1-beat credit after release.
